// File: rtl/mem_ctrl_pkg.sv
// Shared types and default address-window constants for the CPU memory access sequencer.
package mem_ctrl_pkg;

  localparam logic [31:0] INT_BASE_DEF    = 32'h0000_1730;
  localparam logic [31:0] INT_LAST_DEF    = 32'h0000_1B2F;
  localparam int          INT_AW_DEF      = 8;
  localparam int          EXT_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    INT_ACC,
    INT_RSP,
    EXT_WAIT,
    RSP
  } state_t;

  // Request captured on accept and held for the whole transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decode: internal-window hit flag plus word offset into the internal RAM.
module mem_region_decode
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_BASE = INT_BASE_DEF,
  parameter logic [31:0] INT_LAST = INT_LAST_DEF,
  parameter int          INT_AW   = INT_AW_DEF
) (
  input  logic [31:0]       i_addr,
  output logic              o_is_int,
  output logic [INT_AW-1:0] o_offset
);

  logic [31:0] w_diff;

  assign w_diff   = i_addr - INT_BASE;
  assign o_is_int = (i_addr >= INT_BASE) && (i_addr <= INT_LAST);
  // Offset wraps within the RAM; only meaningful when o_is_int is set.
  assign o_offset = INT_AW'(w_diff >> 2);

endmodule

// File: rtl/mem_access_ctrl.sv
// Routes each CPU load/store to the internal RAM (fixed latency) or the external
// req/ack bus (variable latency, timeout), stalling the core via cpu_busy.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_BASE    = INT_BASE_DEF,
  parameter logic [31:0] INT_LAST    = INT_LAST_DEF,
  parameter int          INT_AW      = INT_AW_DEF,
  parameter int          EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              cpu_err,
  output logic              int_en,
  output logic              int_we,
  output logic [INT_AW-1:0] int_addr,
  output logic [31:0]       int_wdata,
  input  logic [31:0]       int_rdata,
  output logic              ext_req,
  output logic              ext_we,
  output logic [31:0]       ext_addr,
  output logic [31:0]       ext_wdata,
  input  logic [31:0]       ext_rdata,
  input  logic              ext_ack
);

  localparam int             CW       = $clog2(EXT_TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(EXT_TIMEOUT - 1);

  if ((INT_LAST - INT_BASE + 32'd1) != 32'd1024 || (32'd4 << INT_AW) != 32'd1024) begin : g_bad_window
    $error("mem_access_ctrl: internal window must span exactly 1 KiB of INT_AW-addressed words");
  end

  state_t            r_state, w_next;
  req_t              r_req;
  logic [INT_AW-1:0] r_off;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_is_int;
  logic [INT_AW-1:0] w_off;
  logic              w_accept, w_ack, w_tmo;
  logic              w_int_en, w_ext_req, w_ready, w_rsp;

  mem_region_decode #(
    .INT_BASE (INT_BASE),
    .INT_LAST (INT_LAST),
    .INT_AW   (INT_AW)
  ) u_decode (
    .i_addr   (cpu_addr),
    .o_is_int (w_is_int),
    .o_offset (w_off)
  );

  assign w_accept = (r_state == IDLE) && cpu_req;
  // Ack is only honoured while the request is up; it beats a same-cycle timeout.
  assign w_ack    = (r_state == EXT_WAIT) && ext_ack;
  assign w_tmo    = (r_state == EXT_WAIT) && !ext_ack && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_int_en  = 1'b0;
    w_ext_req = 1'b0;
    w_ready   = 1'b0;
    w_rsp     = 1'b0;
    unique case (r_state)
      IDLE:     if (cpu_req) w_next = w_is_int ? INT_ACC : EXT_WAIT;
      INT_ACC:  begin w_int_en = 1'b1; w_next = INT_RSP; end
      INT_RSP:  begin w_ready = 1'b1; w_next = IDLE; end
      EXT_WAIT: begin
        w_ext_req = 1'b1;
        if (w_ack || w_tmo) w_next = RSP;
      end
      RSP:      begin w_ready = 1'b1; w_rsp = 1'b1; w_next = IDLE; end
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        r_off <= w_off;
      end
      if (r_state == EXT_WAIT) r_cnt <= r_cnt + CW'(1);
      else                     r_cnt <= '0;
      // Stores never touch the returned-data register.
      if (!r_req.we) begin
        if (r_state == INT_RSP) r_rdata <= int_rdata;
        else if (w_ack)         r_rdata <= ext_rdata;
        else if (w_tmo)         r_rdata <= '0;
      end
      if (w_ack)      r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end

  // Internal load data is forwarded straight through in the response cycle.
  assign cpu_rdata = (r_state == INT_RSP && !r_req.we) ? int_rdata : r_rdata;
  assign cpu_ready = w_ready;
  assign cpu_busy  = (r_state != IDLE);
  assign cpu_err   = w_rsp && r_err;

  assign int_en    = w_int_en;
  assign int_we    = w_int_en && r_req.we;
  assign int_addr  = r_off;
  assign int_wdata = r_req.wdata;

  assign ext_req   = w_ext_req;
  assign ext_we    = r_req.we;
  assign ext_addr  = r_req.addr;
  assign ext_wdata = r_req.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed test-plan scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_busy, cpu_err;
  logic        int_en, int_we;
  logic [7:0]  int_addr;
  logic [31:0] int_wdata, int_rdata;
  logic        ext_req, ext_we, ext_ack;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .cpu_err(cpu_err),
    .int_en(int_en), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_rdata(int_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'd0) ? 32'hDEAD_BEEF : {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  // Internal RAM device: 1-cycle read latency.
  logic [31:0] ram [256];
  logic        wr  [256];
  always @(posedge clk) begin
    if (int_en) begin
      if (int_we) begin
        ram[int_addr] <= int_wdata;
        wr[int_addr]  <= 1'b1;
      end else begin
        int_rdata <= (wr[int_addr] === 1'b1) ? ram[int_addr] : init_word(int_addr);
      end
    end
  end

  // Reference model state: expected RAM contents and last returned load data.
  logic [31:0] mref [256];
  logic [31:0] exp_rd;

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] erdv,
                       output int elat, output int ereqc, output int eenc,
                       output logic [7:0] eia, output logic [31:0] erd, output logic eerr);
    logic is_int;
    is_int = (addr >= 32'h1730) && (addr <= 32'h1B2F);
    eia = 8'((addr - 32'h1730) >> 2);
    eerr = 1'b0;
    if (is_int) begin
      elat = 2; ereqc = 0; eenc = 1;
      erd = we ? exp_rd : mref[eia];
      if (we) mref[eia] = wd;
    end else if (ack_at >= 1 && ack_at <= 16) begin
      elat = ack_at + 1; ereqc = ack_at; eenc = 0;
      erd = we ? exp_rd : erdv;
    end else begin
      elat = 17; ereqc = 16; eenc = 0;
      erd = we ? exp_rd : 32'h0;
      eerr = 1'b1;
    end
    exp_rd = erd;
  endtask

  // Drives one request from a negedge in IDLE and observes it to completion.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] erdv,
                         output int lat, output int reqc, output int enc,
                         output logic [7:0] ia, output logic iwe,
                         output logic [31:0] rd, output logic err, output int bad);
    lat = -1; reqc = 0; enc = 0; ia = 8'h0; iwe = 1'b0; rd = 32'h0; err = 1'b0; bad = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      ext_ack = 1'b0;
      ext_rdata = $urandom;
      if (cpu_busy !== 1'b1) bad++;
      if (int_en === 1'b1) begin
        enc++; ia = int_addr; iwe = int_we;
        if (int_wdata !== wd) bad++;
      end
      if (ext_req === 1'b1) begin
        reqc++;
        if (ext_addr !== addr || ext_we !== we || ext_wdata !== wd) bad++;
        if (reqc == ack_at) begin ext_ack = 1'b1; ext_rdata = erdv; end
      end
      if (cpu_ready === 1'b1) begin
        lat = k; rd = cpu_rdata; err = cpu_err;
        break;
      end else if (cpu_err !== 1'b0) bad++;
    end
    @(negedge clk);
    ext_ack = 1'b0;
    if (cpu_busy !== 1'b0 || cpu_ready !== 1'b0) bad++;
  endtask

  task automatic test_reset();
    checks++;
    if ({cpu_ready, cpu_busy, cpu_err, int_en, int_we, ext_req, ext_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {cpu_ready, cpu_busy, cpu_err, int_en, int_we, ext_req, ext_we});
    end
    checks++;
    if ({cpu_rdata, ext_addr, ext_wdata, int_wdata, int_addr} !== '0) begin
      errors++; $display("FAIL reset_data got rdata=%h ext_addr=%h int_addr=%h want 0", cpu_rdata, ext_addr, int_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", cpu_busy); end
    exp_rd = 32'h0;
  endtask

  task automatic test_int_load();
    int lat, reqc, enc, bad, elat, ereqc, eenc; logic [7:0] ia, eia; logic iwe, err, eerr; logic [31:0] rd, erd;
    model(1'b0, 32'h1730, 32'h0, 0, 32'h0, elat, ereqc, eenc, eia, erd, eerr);
    run_txn(1'b0, 32'h1730, 32'h0, 0, 32'h0, lat, reqc, enc, ia, iwe, rd, err, bad);
    checks++; if (lat !== 2) begin errors++; $display("FAIL int_load_latency got %0d want 2", lat); end
    checks++; if (enc !== 1 || ia !== 8'h00 || iwe !== 1'b0) begin errors++; $display("FAIL int_load_en got en=%0d addr=%h we=%b want 1/00/0", enc, ia, iwe); end
    checks++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin errors++; $display("FAIL int_load_data got %h err=%b want deadbeef err=0", rd, err); end
    checks++; if (reqc !== 0 || bad !== 0) begin errors++; $display("FAIL int_load_side got ext_req_cycles=%0d bad=%0d want 0/0", reqc, bad); end
  endtask

  task automatic test_int_store();
    int lat, reqc, enc, bad, elat, ereqc, eenc; logic [7:0] ia, eia; logic iwe, err, eerr; logic [31:0] rd, erd;
    model(1'b1, 32'h1B2F, 32'h1234_5678, 0, 32'h0, elat, ereqc, eenc, eia, erd, eerr);
    run_txn(1'b1, 32'h1B2F, 32'h1234_5678, 0, 32'h0, lat, reqc, enc, ia, iwe, rd, err, bad);
    checks++; if (lat !== 2 || enc !== 1 || ia !== 8'hFF || iwe !== 1'b1) begin
      errors++; $display("FAIL int_store got lat=%0d en=%0d addr=%h we=%b want 2/1/ff/1", lat, enc, ia, iwe); end
    checks++; if (rd !== 32'hDEAD_BEEF || reqc !== 0 || bad !== 0) begin
      errors++; $display("FAIL int_store_rdata got %h ext=%0d bad=%0d want deadbeef/0/0", rd, reqc, bad); end
    model(1'b0, 32'h1B2F, 32'h0, 0, 32'h0, elat, ereqc, eenc, eia, erd, eerr);
    run_txn(1'b0, 32'h1B2F, 32'h0, 0, 32'h0, lat, reqc, enc, ia, iwe, rd, err, bad);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL int_store_readback got %h want 12345678", rd); end
  endtask

  task automatic test_ext_ack();
    int lat, reqc, enc, bad, elat, ereqc, eenc; logic [7:0] ia, eia; logic iwe, err, eerr; logic [31:0] rd, erd;
    model(1'b0, 32'h1B30, 32'h0, 3, 32'hCAFE_F00D, elat, ereqc, eenc, eia, erd, eerr);
    run_txn(1'b0, 32'h1B30, 32'h0, 3, 32'hCAFE_F00D, lat, reqc, enc, ia, iwe, rd, err, bad);
    checks++; if (reqc !== 3 || lat !== 4 || enc !== 0) begin
      errors++; $display("FAIL ext_ack_timing got req=%0d lat=%0d en=%0d want 3/4/0", reqc, lat, enc); end
    checks++; if (rd !== 32'hCAFE_F00D || err !== 1'b0 || bad !== 0) begin
      errors++; $display("FAIL ext_ack_data got %h err=%b bad=%0d want cafef00d/0/0", rd, err, bad); end
  endtask

  task automatic test_timeout();
    int lat, reqc, enc, bad, elat, ereqc, eenc, stray; logic [7:0] ia, eia; logic iwe, err, eerr; logic [31:0] rd, erd;
    model(1'b0, 32'h1000, 32'h0, 0, 32'h0, elat, ereqc, eenc, eia, erd, eerr);
    run_txn(1'b0, 32'h1000, 32'h0, 0, 32'h0, lat, reqc, enc, ia, iwe, rd, err, bad);
    checks++; if (reqc !== 16 || lat !== 17) begin errors++; $display("FAIL timeout_len got req=%0d lat=%0d want 16/17", reqc, lat); end
    checks++; if (err !== 1'b1 || rd !== 32'h0 || bad !== 0) begin
      errors++; $display("FAIL timeout_err got err=%b rdata=%h bad=%0d want 1/0/0", err, rd, bad); end
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      ext_ack = 1'b1; ext_rdata = 32'h5555_AAAA;
      @(negedge clk);
      if (cpu_ready !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'h0) stray++;
    end
    ext_ack = 1'b0;
    checks++; if (stray !== 0) begin errors++; $display("FAIL stray_ack got %0d disturbed cycles want 0", stray); end
  endtask

  task automatic test_reset_mid();
    int lat, reqc, enc, bad, elat, ereqc, eenc, rdy; logic [7:0] ia, eia; logic iwe, err, eerr; logic [31:0] rd, erd;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000;
    @(negedge clk); cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL reset_mid_pre ext_req got %b want 1", ext_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ext_req !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async got req=%b busy=%b want 0/0", ext_req, cpu_busy); end
    rdy = 0;
    repeat (3) begin @(negedge clk); if (cpu_ready !== 1'b0) rdy++; end
    rst_n = 1'b1;
    exp_rd = 32'h0;
    @(negedge clk); if (cpu_ready !== 1'b0 || cpu_busy !== 1'b0) rdy++;
    checks++; if (rdy !== 0) begin errors++; $display("FAIL reset_mid_noready got %0d bad cycles want 0", rdy); end
    model(1'b0, 32'h172F, 32'h0, 2, 32'h0BAD_F00D, elat, ereqc, eenc, eia, erd, eerr);
    run_txn(1'b0, 32'h172F, 32'h0, 2, 32'h0BAD_F00D, lat, reqc, enc, ia, iwe, rd, err, bad);
    checks++; if (reqc !== 2 || enc !== 0 || lat !== 3 || rd !== 32'h0BAD_F00D || bad !== 0) begin
      errors++; $display("FAIL below_window got req=%0d en=%0d lat=%0d rd=%h bad=%0d want 2/0/3/0badf00d/0", reqc, enc, lat, rd, bad); end
  endtask

  task automatic test_back_to_back();
    logic [8:1] busy_v, rdy_v, en_v, req_v;
    logic [31:0] rd1, rd2, exp1;
    int seen;
    busy_v = '0; rdy_v = '0; en_v = '0; req_v = '0; rd1 = '0; rd2 = '0; seen = 0;
    exp1 = mref[8'h34];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1800;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ext_ack = 1'b0;
      busy_v[k] = cpu_busy; rdy_v[k] = cpu_ready; en_v[k] = int_en; req_v[k] = ext_req;
      if (int_en === 1'b1 && int_addr !== 8'h34) en_v[k] = 1'bx;
      if (cpu_ready === 1'b1 && seen == 0) rd1 = cpu_rdata;
      if (cpu_ready === 1'b1 && seen > 0) rd2 = cpu_rdata;
      if (k == 2) cpu_addr = 32'h2000;
      if (ext_req === 1'b1) begin
        seen++;
        cpu_req = 1'b0;
        if (ext_addr !== 32'h2000) req_v[k] = 1'bx;
        if (seen == 2) begin ext_ack = 1'b1; ext_rdata = 32'h600D_F00D; end
      end
    end
    exp_rd = 32'h600D_F00D;
    checks++; if (busy_v !== 8'b0011_1011) begin errors++; $display("FAIL b2b_busy got %b want 00111011", busy_v); end
    checks++; if (rdy_v !== 8'b0010_0010 || en_v !== 8'b0000_0001 || req_v !== 8'b0001_1000) begin
      errors++; $display("FAIL b2b_accepts got rdy=%b en=%b req=%b want 00100010/00000001/00011000", rdy_v, en_v, req_v); end
    checks++; if (rd1 !== exp1 || rd2 !== 32'h600D_F00D) begin
      errors++; $display("FAIL b2b_data got %h/%h want %h/600df00d", rd1, rd2, exp1); end
  endtask

  task automatic test_random();
    int lat, reqc, enc, bad, elat, ereqc, eenc, ack_at; logic [7:0] ia, eia; logic iwe, err, eerr; logic [31:0] rd, erd;
    logic we; logic [31:0] addr, wd, erdv;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 5))
            0: addr = 32'h1730; 1: addr = 32'h1B2F; 2: addr = 32'h172F;
            3: addr = 32'h1B30; 4: addr = 32'h0;    default: addr = 32'hFFFF_FFFF;
          endcase
        end
        1, 2: addr = 32'h1730 + 32'($urandom_range(0, 1023));
        default: addr = $urandom;
      endcase
      we = 1'($urandom_range(0, 1));
      wd = $urandom; erdv = $urandom;
      ack_at = $urandom_range(0, 18);
      model(we, addr, wd, ack_at, erdv, elat, ereqc, eenc, eia, erd, eerr);
      run_txn(we, addr, wd, ack_at, erdv, lat, reqc, enc, ia, iwe, rd, err, bad);
      checks++;
      if (lat !== elat || reqc !== ereqc || enc !== eenc || rd !== erd || err !== eerr || bad !== 0 ||
          (eenc == 1 && (ia !== eia || iwe !== we))) begin
        errors++;
        $display("FAIL rand_%0d addr=%h we=%b got lat=%0d req=%0d en=%0d ia=%h rd=%h err=%b bad=%0d want lat=%0d req=%0d en=%0d ia=%h rd=%h err=%b",
                 n, addr, we, lat, reqc, enc, ia, rd, err, bad, elat, ereqc, eenc, eia, erd, eerr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mref[i] = init_word(8'(i));
    exp_rd = 32'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ext_ack = 1'b0; ext_rdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_int_load();
    test_int_store();
    test_ext_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
